alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Execute-issue stage directly upstream of the 32-bit ALU. Decodes a MIPS instruction word, builds the ALU select code and operands, drives the combinational ALU, and captures its result and flags in a one-entry output register with valid/ready handshakes. It also flags signed-overflow traps and illegal encodings, and keeps a saturating trap counter.

## Interface
- `TRAP_CNT_W`, default 8: width of the saturating trap counter.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream offers an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `instr`  in  32  MIPS instruction word.
- `rs_val`, `rt_val`  in  32 each  register operands.
- `alu_s`  out  4  ALU select, combinational from `instr`.
- `alu_a`, `alu_b`  out  32 each  ALU operands, combinational.
- `alu_r`  in  32  ALU result.
- `alu_zero`, `alu_ovf`, `alu_cout`  in  1 each  ALU flags.
- `out_valid`  out  1  registered result available.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  32  registered ALU result.
- `out_dest`  out  5  destination register number.
- `out_we`  out  1  writeback enable.
- `out_zero`, `out_cout`  out  1 each  registered flags.
- `out_trap`  out  1  signed overflow on a trapping op.
- `out_illegal`  out  1  unsupported encoding.
- `trap_count`  out  TRAP_CNT_W  saturating count of accepted traps.

## Operation
- ALU select encoding: 0000 and, 0001 or, 0010 add, 0011 xor, 0100 sub, 0101 sra, 0110 sll, 0111 nor. `alu_s[3]` is always 0. For shifts, A is the value and B[4:0] is the shift amount.
- R-type (op=0x00), `out_dest`=rd:
  - funct 0x20/0x21 add/addu → add, A=rs, B=rt.
  - 0x22/0x23 sub/subu → sub, A=rs, B=rt.
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, with A=rs, B=rt.
  - 0x00 sll and 0x03 sra: A=rt, B=zero-extended shamt.
  - 0x04 sllv and 0x07 srav: A=rt, B=rs.
- I-type, `out_dest`=rt:
  - 0x08 addi and 0x09 addiu → add, with B=sign-extended imm16.
  - 0x0C andi, 0x0D ori, 0x0E xori, with B=zero-extended imm16.
  - A=rs for all I-type.
- Trapping ops are add, sub and addi. `out_trap` = `alu_ovf` for these ops and 0 otherwise.
- Illegal: any other op or funct. The ALU is driven with and (0000), operands are zero, and `out_illegal`=1.
- `out_we` = !trap && !illegal && dest≠0.
- `trap_count` increments by 1 on each accepted transfer with trap=1. It saturates at all-ones.

## Timing
- `in_ready` = !out_valid || out_ready, which is a pass-through bubble-free pipeline.
- A transfer is accepted when in_valid && in_ready. The output register loads on that edge, so latency is 1 cycle. `alu_*` outputs are combinational from the current `instr`/`rs_val`/`rt_val`.
- `out_valid` sets on accept. It clears on out_ready with no new accept.
- Simultaneous drain and accept: the register reloads and `out_valid` stays 1.
- While out_valid && !out_ready, all `out_*` signals hold stable.
- Reset: `out_valid`=0, `out_result`=0, `out_dest`=0, and `out_we`, `out_zero`, `out_cout`, `out_trap`, `out_illegal` all 0. `trap_count`=0.
- Reset mid-transfer discards the held result, and `in_ready` reads 1 in the first cycle after reset.
- Trap counter saturation: an increment at all-ones leaves the counter at all-ones.

## Structure
- Shared package:
  - ALU select constants (ALU_AND … ALU_NOR).
  - MIPS opcode and funct constants.
  - Packed struct for the decoded control word {s, use_imm, sign_ext, shamt_sel, swap_ab, trap_en, illegal, dest_sel}.
- One combinational sub-module, `alu_decode`: instr → control word. The stage module holds operand muxing, the output register, the handshake and the counter.

## Test plan
- add rs=0x7FFFFFFF, rt=1, rd=3 → after 1 cycle out_result=0x80000000, out_trap=1, out_we=0, trap_count=1.
- addu with the same operands → out_trap=0, out_we=1, out_dest=3.
- addi rs=5, imm=0xFFFF → alu_s=0010, alu_b=0xFFFFFFFF, out_result=4. ori with the same imm → alu_b=0x0000FFFF.
- sra rt=0x80000000, shamt=4 → alu_a=0x80000000, alu_b=4, out_result=0xF8000000. sub rs=rt=9 → out_zero=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Then out_ready=1 → drain and new accept occur in the same cycle, and out_valid stays 1.
- op=0x3F → out_illegal=1, out_we=0. Also cover 256 consecutive trapping adds with TRAP_CNT_W=8 → trap_count=0xFF. Assert rst with out_valid=1 → out_valid=0 on the next cycle.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and types for the ALU issue stage: ALU select codes,
// MIPS opcode/funct values and the decoded control word.
// Purely declarative; no logic, no latency, no flow control.
package alu_issue_stage_pkg;

  // ALU select codes (bit 3 is always zero)
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  // Destination field select
  localparam logic DEST_RT = 1'b0;
  localparam logic DEST_RD = 1'b1;

  // Decoded control word. swap_ab puts rt on A (and rs on B for variable shifts).
  typedef struct packed {
    logic [3:0] s;
    logic       use_imm;
    logic       sign_ext;
    logic       shamt_sel;
    logic       swap_ab;
    logic       trap_en;
    logic       illegal;
    logic       dest_sel;
  } ctrl_t;

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Decodes a MIPS instruction word into the ALU control word.
// Purely combinational, zero latency.
// No flow control; the stage qualifies the result with its handshake.
module alu_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_unused;

  assign w_op     = i_instr[31:26];
  assign w_funct  = i_instr[5:0];
  // Register/immediate fields are consumed by the stage, not the decoder.
  assign w_unused = ^i_instr[25:6];

  // Opcode/funct to control word; anything unrecognised becomes an illegal AND.
  always_comb begin
    o_ctrl   = '0;
    o_ctrl.s = ALU_AND;
    if (w_op == OP_RTYPE) begin
      o_ctrl.dest_sel = DEST_RD;
      case (w_funct)
        FN_ADD:  begin o_ctrl.s = ALU_ADD; o_ctrl.trap_en = 1'b1; end
        FN_ADDU: o_ctrl.s = ALU_ADD;
        FN_SUB:  begin o_ctrl.s = ALU_SUB; o_ctrl.trap_en = 1'b1; end
        FN_SUBU: o_ctrl.s = ALU_SUB;
        FN_AND:  o_ctrl.s = ALU_AND;
        FN_OR:   o_ctrl.s = ALU_OR;
        FN_XOR:  o_ctrl.s = ALU_XOR;
        FN_NOR:  o_ctrl.s = ALU_NOR;
        FN_SLL:  begin o_ctrl.s = ALU_SLL; o_ctrl.swap_ab = 1'b1; o_ctrl.shamt_sel = 1'b1; end
        FN_SRA:  begin o_ctrl.s = ALU_SRA; o_ctrl.swap_ab = 1'b1; o_ctrl.shamt_sel = 1'b1; end
        FN_SLLV: begin o_ctrl.s = ALU_SLL; o_ctrl.swap_ab = 1'b1; end
        FN_SRAV: begin o_ctrl.s = ALU_SRA; o_ctrl.swap_ab = 1'b1; end
        default: o_ctrl.illegal = 1'b1;
      endcase
    end else begin
      o_ctrl.dest_sel = DEST_RT;
      case (w_op)
        OP_ADDI:  begin
          o_ctrl.s = ALU_ADD; o_ctrl.use_imm = 1'b1; o_ctrl.sign_ext = 1'b1; o_ctrl.trap_en = 1'b1;
        end
        OP_ADDIU: begin o_ctrl.s = ALU_ADD; o_ctrl.use_imm = 1'b1; o_ctrl.sign_ext = 1'b1; end
        OP_ANDI:  begin o_ctrl.s = ALU_AND; o_ctrl.use_imm = 1'b1; end
        OP_ORI:   begin o_ctrl.s = ALU_OR;  o_ctrl.use_imm = 1'b1; end
        OP_XORI:  begin o_ctrl.s = ALU_XOR; o_ctrl.use_imm = 1'b1; end
        default:  o_ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 32-bit ALU: decode, operand mux, result register, trap counter.
// One cycle from accept to out_valid; alu_* outputs are combinational from instr/rs_val/rt_val.
// in_ready = !out_valid || out_ready, so a stalled result holds and a draining one is replaced bubble-free.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int TRAP_CNT_W = 8
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [31:0]           rs_val,
  input  logic [31:0]           rt_val,
  output logic [3:0]            alu_s,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_r,
  input  logic                  alu_zero,
  input  logic                  alu_ovf,
  input  logic                  alu_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_result,
  output logic [4:0]            out_dest,
  output logic                  out_we,
  output logic                  out_zero,
  output logic                  out_cout,
  output logic                  out_trap,
  output logic                  out_illegal,
  output logic [TRAP_CNT_W-1:0] trap_count
);

  ctrl_t                 w_ctrl;
  logic [31:0]           w_alu_a;
  logic [31:0]           w_alu_b;
  logic [4:0]            w_dest;
  logic                  w_trap;
  logic                  w_we;
  logic                  w_accept;

  logic                  r_out_valid;
  logic [31:0]           r_out_result;
  logic [4:0]            r_out_dest;
  logic                  r_out_we;
  logic                  r_out_zero;
  logic                  r_out_cout;
  logic                  r_out_trap;
  logic                  r_out_illegal;
  logic [TRAP_CNT_W-1:0] r_trap_count;

  alu_decode u_decode (
    .i_instr (instr),
    .o_ctrl  (w_ctrl)
  );

  // Operand selection; illegal encodings present zero operands to the ALU.
  always_comb begin
    w_alu_a = w_ctrl.swap_ab ? rt_val : rs_val;
    if (w_ctrl.shamt_sel)
      w_alu_b = {27'd0, instr[10:6]};
    else if (w_ctrl.use_imm)
      w_alu_b = w_ctrl.sign_ext ? {{16{instr[15]}}, instr[15:0]} : {16'd0, instr[15:0]};
    else if (w_ctrl.swap_ab)
      w_alu_b = rs_val;
    else
      w_alu_b = rt_val;
    if (w_ctrl.illegal) begin
      w_alu_a = '0;
      w_alu_b = '0;
    end
  end

  assign alu_s    = w_ctrl.s;
  assign alu_a    = w_alu_a;
  assign alu_b    = w_alu_b;

  assign w_dest   = (w_ctrl.dest_sel == DEST_RD) ? instr[15:11] : instr[20:16];
  assign w_trap   = w_ctrl.trap_en & alu_ovf;
  assign w_we     = !w_trap && !w_ctrl.illegal && (w_dest != 5'd0);
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // One-entry output register: load on accept, clear valid on drain without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_dest    <= '0;
      r_out_we      <= 1'b0;
      r_out_zero    <= 1'b0;
      r_out_cout    <= 1'b0;
      r_out_trap    <= 1'b0;
      r_out_illegal <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_result  <= alu_r;
      r_out_dest    <= w_dest;
      r_out_we      <= w_we;
      r_out_zero    <= alu_zero;
      r_out_cout    <= alu_cout;
      r_out_trap    <= w_trap;
      r_out_illegal <= w_ctrl.illegal;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  // Saturating count of accepted trapping transfers.
  always_ff @(posedge clk) begin
    if (rst)
      r_trap_count <= '0;
    else if (w_accept && w_trap && (r_trap_count != {TRAP_CNT_W{1'b1}}))
      r_trap_count <= r_trap_count + TRAP_CNT_W'(1);
  end

  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_dest    = r_out_dest;
  assign out_we      = r_out_we;
  assign out_zero    = r_out_zero;
  assign out_cout    = r_out_cout;
  assign out_trap    = r_out_trap;
  assign out_illegal = r_out_illegal;
  assign trap_count  = r_trap_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the alu_* port, instruction-level reference model,
// scoreboard queue filled on accept and checked on drain, plus directed handshake/reset cases.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        we;
    logic        zero;
    logic        cout;
    logic        trap;
    logic        ill;
    logic [7:0]  tc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [3:0]  alu_s;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_r;
  logic        alu_zero;
  logic        alu_ovf;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_we;
  logic        out_zero;
  logic        out_cout;
  logic        out_trap;
  logic        out_illegal;
  logic [7:0]  trap_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        force_rdy;
  logic        rand_bp;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [7:0]  tc_model;
  logic [32:0] alu_w;

  alu_issue_stage #(.TRAP_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_we(out_we), .out_zero(out_zero), .out_cout(out_cout),
    .out_trap(out_trap), .out_illegal(out_illegal), .trap_count(trap_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Behavioural 32-bit ALU driven by the stage
  always_comb begin
    alu_w    = '0;
    alu_r    = '0;
    alu_ovf  = 1'b0;
    alu_cout = 1'b0;
    alu_zero = 1'b0;
    case (alu_s)
      4'b0000: alu_r = alu_a & alu_b;
      4'b0001: alu_r = alu_a | alu_b;
      4'b0011: alu_r = alu_a ^ alu_b;
      4'b0111: alu_r = ~(alu_a | alu_b);
      4'b0101: alu_r = $signed(alu_a) >>> alu_b[4:0];
      4'b0110: alu_r = alu_a << alu_b[4:0];
      4'b0010: begin
        alu_w    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r    = alu_w[31:0];
        alu_cout = alu_w[32];
        alu_ovf  = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      4'b0100: begin
        alu_w    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_r    = alu_w[31:0];
        alu_cout = alu_w[32];
        alu_ovf  = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      default: alu_r = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_r == 32'd0);
  end

  // out_ready driver: fixed level or random backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : force_rdy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Instruction-level reference: what the stage must register for this instruction
  function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] se;
    logic [31:0] ze;
    logic [32:0] s;
    logic        ovf;
    e   = '0;
    op  = ins[31:26];
    fn  = ins[5:0];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0000, ins[15:0]};
    s   = '0;
    ovf = 1'b0;
    if (op == 6'h00) begin
      e.dest = ins[15:11];
      case (fn)
        6'h20, 6'h21: begin
          s      = {1'b0, a} + {1'b0, b};
          e.res  = s[31:0];
          e.cout = s[32];
          ovf    = (a[31] == b[31]) && (e.res[31] != a[31]);
          e.trap = (fn == 6'h20) && ovf;
        end
        6'h22, 6'h23: begin
          e.res  = a - b;
          e.cout = (a >= b);
          ovf    = (a[31] != b[31]) && (e.res[31] != a[31]);
          e.trap = (fn == 6'h22) && ovf;
        end
        6'h24:   e.res = a & b;
        6'h25:   e.res = a | b;
        6'h26:   e.res = a ^ b;
        6'h27:   e.res = ~(a | b);
        6'h00:   e.res = b << ins[10:6];
        6'h03:   e.res = $signed(b) >>> ins[10:6];
        6'h04:   e.res = b << a[4:0];
        6'h07:   e.res = $signed(b) >>> a[4:0];
        default: e.ill = 1'b1;
      endcase
    end else begin
      e.dest = ins[20:16];
      case (op)
        6'h08, 6'h09: begin
          s      = {1'b0, a} + {1'b0, se};
          e.res  = s[31:0];
          e.cout = s[32];
          ovf    = (a[31] == se[31]) && (e.res[31] != a[31]);
          e.trap = (op == 6'h08) && ovf;
        end
        6'h0C:   e.res = a & ze;
        6'h0D:   e.res = a | ze;
        6'h0E:   e.res = a ^ ze;
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e.res  = '0;
      e.cout = 1'b0;
    end
    e.zero = (e.res == 32'd0);
    e.we   = !e.trap && !e.ill && (e.dest != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fns [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                             6'h26, 6'h27, 6'h00, 6'h03, 6'h04, 6'h07};
    logic [5:0] ops [5]  = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E};
    int sel;
    sel = $urandom_range(0, 18);
    if (sel < 12)
      return rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fns[sel]);
    else if (sel == 12)
      return rtype(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'h2A);
    else if (sel < 18)
      return itype(ops[sel-13], 5'($urandom), 5'($urandom), 16'($urandom));
    else
      return itype(6'h23, 5'($urandom), 5'($urandom), 16'($urandom));
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: compare on drain, then record any accept happening on the same edge
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      tc_model = 8'h00;
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("sb_result", out_result, mon_e.res);
          if (!mon_e.ill) chk("sb_dest", {27'd0, out_dest}, {27'd0, mon_e.dest});
          chk("sb_we",      {31'd0, out_we},      {31'd0, mon_e.we});
          chk("sb_zero",    {31'd0, out_zero},    {31'd0, mon_e.zero});
          chk("sb_cout",    {31'd0, out_cout},    {31'd0, mon_e.cout});
          chk("sb_trap",    {31'd0, out_trap},    {31'd0, mon_e.trap});
          chk("sb_illegal", {31'd0, out_illegal}, {31'd0, mon_e.ill});
          chk("sb_trap_count", {24'd0, trap_count}, {24'd0, mon_e.tc});
        end
      end
      if (in_valid && in_ready) begin
        mon_e = ref_exec(instr, rs_val, rt_val);
        if (mon_e.trap && tc_model != 8'hFF) tc_model = tc_model + 8'd1;
        mon_e.tc = tc_model;
        sbq.push_back(mon_e);
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = ins;
    rs_val   = a;
    rt_val   = b;
  endtask

  // Returns at posedge+1 of the cycle after the accepting edge
  task automatic wait_acc();
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    drive(ins, a, b);
    wait_acc();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (sbq.size() == 0 && !out_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  exp_t exp_a;
  exp_t exp_b;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    rs_val    = '0;
    rt_val    = '0;
    force_rdy = 1'b1;
    rand_bp   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid",   {31'd0, out_valid},   32'd0);
    chk("rst_out_result",  out_result,           32'd0);
    chk("rst_out_dest",    {27'd0, out_dest},    32'd0);
    chk("rst_out_we",      {31'd0, out_we},      32'd0);
    chk("rst_out_zero",    {31'd0, out_zero},    32'd0);
    chk("rst_out_cout",    {31'd0, out_cout},    32'd0);
    chk("rst_out_trap",    {31'd0, out_trap},    32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_trap_count",  {24'd0, trap_count},  32'd0);
    chk("rst_in_ready",    {31'd0, in_ready},    32'd1);

    // Signed overflow on add traps and suppresses writeback
    send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_ovf_result", out_result, 32'h8000_0000);
    chk("add_ovf_trap", {31'd0, out_trap}, 32'd1);
    chk("add_ovf_we", {31'd0, out_we}, 32'd0);
    chk("add_ovf_trap_count", {24'd0, trap_count}, 32'd1);

    // addu never traps
    send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h7FFF_FFFF, 32'h0000_0001);
    chk("addu_trap", {31'd0, out_trap}, 32'd0);
    chk("addu_we", {31'd0, out_we}, 32'd1);
    chk("addu_dest", {27'd0, out_dest}, 32'd3);

    // addi sign-extends, ori zero-extends
    drive(itype(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd5, 32'h1234_5678);
    #1;
    chk("addi_alu_s", {28'd0, alu_s}, 32'd2);
    chk("addi_alu_b", alu_b, 32'hFFFF_FFFF);
    wait_acc();
    chk("addi_result", out_result, 32'd4);
    drive(itype(6'h0D, 5'd1, 5'd4, 16'hFFFF), 32'd5, 32'h1234_5678);
    #1;
    chk("ori_alu_b", alu_b, 32'h0000_FFFF);
    wait_acc();

    // Immediate shift: A=rt, B=shamt
    drive(rtype(5'd9, 5'd5, 5'd6, 5'd4, 6'h03), 32'h0000_00FF, 32'h8000_0000);
    #1;
    chk("sra_alu_a", alu_a, 32'h8000_0000);
    chk("sra_alu_b", alu_b, 32'd4);
    wait_acc();
    chk("sra_result", out_result, 32'hF800_0000);

    send(rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h22), 32'd9, 32'd9);
    chk("sub_zero", {31'd0, out_zero}, 32'd1);

    // Illegal opcode: AND with zero operands
    drive(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    chk("ill_alu_s", {28'd0, alu_s}, 32'd0);
    chk("ill_alu_a", alu_a, 32'd0);
    chk("ill_alu_b", alu_b, 32'd0);
    wait_acc();
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_we", {31'd0, out_we}, 32'd0);

    // Random instructions under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) send(rnd_instr(), rnd_val(), rnd_val());
    rand_bp = 1'b0;
    drain();

    // Directed stall: result held for 3 cycles, then drain+accept on one edge
    force_rdy = 1'b0;
    @(posedge clk);
    #1;
    exp_a = ref_exec(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h26), 32'hA5A5_0F0F, 32'h0F0F_FFFF);
    send(rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h26), 32'hA5A5_0F0F, 32'h0F0F_FFFF);
    exp_b = ref_exec(rtype(5'd3, 5'd4, 5'd11, 5'd0, 6'h27), 32'h0000_00F0, 32'h0000_000F);
    drive(rtype(5'd3, 5'd4, 5'd11, 5'd0, 6'h27), 32'h0000_00F0, 32'h0000_000F);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_result", out_result, exp_a.res);
      chk("stall_out_dest", {27'd0, out_dest}, {27'd0, exp_a.dest});
      chk("stall_out_we", {31'd0, out_we}, {31'd0, exp_a.we});
    end
    @(posedge clk);
    #1 force_rdy = 1'b1;
    @(negedge clk);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("reload_out_valid", {31'd0, out_valid}, 32'd1);
    chk("reload_out_result", out_result, exp_b.res);
    drain();

    // Counter saturation: 256 trapping adds from a cleared counter
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      send(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'h0000_0001);
      if (i == 0)   chk("sat_first", {24'd0, trap_count}, 32'd1);
      if (i == 253) chk("sat_254", {24'd0, trap_count}, 32'd254);
    end
    chk("sat_final", {24'd0, trap_count}, 32'h0000_00FF);
    drain();

    // Reset while holding a stalled result
    force_rdy = 1'b0;
    @(posedge clk);
    #1;
    send(itype(6'h0C, 5'd1, 5'd2, 16'h00FF), 32'h1234_5678, 32'd0);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_result", out_result, 32'd0);
    chk("post_rst_trap_count", {24'd0, trap_count}, 32'd0);
    force_rdy = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
